// File: rtl/fs_en_rate_meter.sv
// fs_en_rate_meter: measures the rate of a single-cycle enable strobe over a
// fixed gate window. It reports the count and the equivalent baud number, and
// qualifies the strobe with lock and stall flags.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | measurement off; counters cleared, locked/stall low
// ST_MEASURE | gate window running; strobes counted every cycle
module fs_en_rate_meter #(
    parameter int unsigned GATE_CYCLES  = 10000,
    parameter int unsigned TOL          = 2,
    parameter int unsigned LOCK_WINDOWS = 3,
    parameter int unsigned STALL_CYCLES = 4096
) (
    input  logic        sys_clk,
    input  logic        glb_rst,
    input  logic        meas_en,
    input  logic        strb_in,
    input  logic [31:0] exp_baud_num,
    output logic [31:0] meas_cnt,
    output logic [31:0] meas_baud,
    output logic        meas_valid,
    output logic        locked,
    output logic        stall
);
    localparam int WIN_W  = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int GAP_W  = $clog2(STALL_CYCLES + 1);
    localparam int GOOD_W = $clog2(LOCK_WINDOWS + 1);

    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(GATE_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_MAX   = GAP_W'(STALL_CYCLES);
    localparam logic [GAP_W-1:0]  GAP_HIT   = GAP_W'(STALL_CYCLES - 1);
    localparam logic [GOOD_W-1:0] GOOD_MAX  = GOOD_W'(LOCK_WINDOWS);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_MEASURE = 1'b1;

    logic [0:0]        state;
    logic [WIN_W-1:0]  win_cnt;
    logic [31:0]       accum;
    logic [GOOD_W-1:0] good_cnt;
    logic [GAP_W-1:0]  gap_cnt;

    logic [31:0]       accum_inc;
    logic [31:0]       baud_new;
    logic [32:0]       diff;
    logic              win_last;
    logic              in_tol;
    logic [GOOD_W-1:0] good_inc;
    logic              stall_hit;

    // Next-count, tolerance and stall-detect terms for the current cycle.
    always_comb begin
        accum_inc = (accum == 32'hFFFF_FFFF) ? accum : accum + 32'(strb_in);
        baud_new  = accum_inc >> 1;
        win_last  = (win_cnt == WIN_LAST);
        // 33-bit magnitude so a large expected value never wraps into tolerance
        if (baud_new >= exp_baud_num)
            diff = {1'b0, baud_new} - {1'b0, exp_baud_num};
        else
            diff = {1'b0, exp_baud_num} - {1'b0, baud_new};
        in_tol    = (diff <= 33'(TOL));
        good_inc  = (good_cnt == GOOD_MAX) ? good_cnt : good_cnt + GOOD_W'(1);
        // true on the edge where gap_cnt reaches the limit, and while it sits there
        stall_hit = !strb_in && (gap_cnt >= GAP_HIT);
    end

    // Window counting, result capture, lock qualification and stall tracking.
    always_ff @(posedge sys_clk) begin
        if (glb_rst) begin
            state      <= ST_IDLE;
            win_cnt    <= '0;
            accum      <= '0;
            good_cnt   <= '0;
            gap_cnt    <= '0;
            meas_cnt   <= '0;
            meas_baud  <= '0;
            meas_valid <= 1'b0;
            locked     <= 1'b0;
            stall      <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if (!meas_en) begin
                state <= ST_IDLE;
                if (state == ST_MEASURE) begin
                    // partial window discarded; results hold their last values
                    win_cnt  <= '0;
                    accum    <= '0;
                    good_cnt <= '0;
                    gap_cnt  <= '0;
                    locked   <= 1'b0;
                    stall    <= 1'b0;
                end
            end else begin
                // the first enabled cycle is already window cycle 0
                state <= ST_MEASURE;
                if (win_last) begin
                    meas_cnt   <= accum_inc;
                    meas_baud  <= baud_new;
                    meas_valid <= 1'b1;
                    win_cnt    <= '0;
                    accum      <= '0;
                    if (in_tol) begin
                        good_cnt <= good_inc;
                        locked   <= (good_inc == GOOD_MAX);
                    end else begin
                        good_cnt <= '0;
                        locked   <= 1'b0;
                    end
                end else begin
                    win_cnt <= win_cnt + WIN_W'(1);
                    accum   <= accum_inc;
                end

                if (strb_in) begin
                    gap_cnt <= '0;
                    stall   <= 1'b0;
                end else if (gap_cnt != GAP_MAX) begin
                    gap_cnt <= gap_cnt + GAP_W'(1);
                end

                // stall wins over any lock acquired at the same window end
                if (stall_hit) begin
                    stall    <= 1'b1;
                    locked   <= 1'b0;
                    good_cnt <= '0;
                end
            end
        end
    end

endmodule
